round_robin_arbiter8: RTL and testbench

ROUND_ROBIN_ARBITER8 -- requirements
Module: round_robin_arbiter8

---
 rtl/arb_pkg.sv | 34 +++
 rtl/onehot_enc8.sv | 23 ++
 rtl/round_robin_arbiter8.sv | 91 +++++++++
 tb/tb_round_robin_arbiter8.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types, sizes and the round-robin search helper for the 8-way arbiter.
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set bit of r in the order ptr, ptr+1, ... (mod 8). Scanning from the far
    // end lets the nearest candidate overwrite the others, so no early exit is needed.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] r,
                                      input logic [IDX_W-1:0]   ptr);
        pick_t            res;
        logic [IDX_W-1:0] k;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = ptr + IDX_W'(i);
            if (r[k]) begin
                res.found = 1'b1;
                res.idx   = k;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/onehot_enc8.sv
// 8-to-3 encoder for a one-hot vector; any input that is not exactly one-hot encodes to 0.
module onehot_enc8
    import arb_pkg::*;
(
    input  logic [7:0] onehot,
    output logic [2:0] idx
);

    logic is_onehot;

    assign is_onehot = (onehot != 8'h00) && ((onehot & (onehot - 8'h01)) == 8'h00);

    // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        idx = '0;
        if (is_onehot) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (onehot[i]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/round_robin_arbiter8.sv
// Eight-requester round-robin arbiter with grant hold and preemption after HOLD_MAX cycles.
module round_robin_arbiter8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid
);

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX - 1);

    state_t     state, state_n;
    logic [2:0] ptr, ptr_n;
    logic [7:0] hold_cnt, hold_n;
    logic [7:0] gnt_n;
    logic       owner_req;
    logic       preempt;
    pick_t      pick;

    // Candidates always exclude the current owner; in IDLE gnt is zero so this is just req.
    assign pick      = rr_pick(req & ~gnt, ptr);
    assign owner_req = |(req & gnt);
    assign preempt   = (hold_cnt >= HOLD_LIM) && pick.found;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        case (state)
            IDLE: begin
                if (pick.found) begin
                    state_n = OWNED;
                    gnt_n   = 8'h01 << pick.idx;
                    ptr_n   = pick.idx + 3'd1;
                    hold_n  = '0;
                end
            end
            OWNED: begin
                if (!owner_req || preempt) begin
                    if (pick.found) begin
                        gnt_n  = 8'h01 << pick.idx;
                        ptr_n  = pick.idx + 3'd1;
                        hold_n = '0;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        hold_n  = '0;
                    end
                end else if (hold_cnt < HOLD_LIM) begin
                    hold_n = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    // Outputs derive only from the registered grant.
    always_comb begin
        gnt_valid = |gnt;
    end

    onehot_enc8 u_enc (
        .onehot (gnt),
        .idx    (gnt_idx)
    );

endmodule

// File: tb/tb_round_robin_arbiter8.sv
// Directed and random checks of round_robin_arbiter8 against a behavioural round-robin model.
module tb_round_robin_arbiter8;

    localparam int HM = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int vectors    = 0;
    int miscompares = 0;

    // Model state: owner is -1 when nobody holds the grant.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;

    round_robin_arbiter8 #(.HOLD_MAX(HM)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [7:0] r, input int p);
        for (int i = 0; i < 8; i++) begin
            if (r[(p + i) % 8]) return (p + i) % 8;
        end
        return -1;
    endfunction

    task automatic model_grant(input int w);
        m_owner = w;
        m_ptr   = (w + 1) % 8;
        m_hold  = 0;
    endtask

    task automatic model_update(input logic [7:0] r, input logic rs);
        logic [7:0] others;
        int         w;
        if (rs) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) model_grant(w);
        end else begin
            others = r;
            others[m_owner] = 1'b0;
            w = pick(others, m_ptr);
            if (!r[m_owner]) begin
                if (w >= 0) model_grant(w);
                else begin
                    m_owner = -1;
                    m_hold  = 0;
                end
            end else if (m_hold >= HM - 1 && w >= 0) begin
                model_grant(w);
            end else if (m_hold < HM - 1) begin
                m_hold++;
            end
        end
    endtask

    task automatic check_outputs();
        logic [7:0] eg;
        logic [2:0] ei;
        logic       ev;
        eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        ei = (m_owner < 0) ? 3'd0 : 3'(m_owner);
        ev = (m_owner >= 0);
        vectors++;
        assert (gnt === eg) else begin
            miscompares++;
            $error("FAIL gnt: observed %h expected %h", gnt, eg);
        end
        vectors++;
        assert (gnt_idx === ei) else begin
            miscompares++;
            $error("FAIL gnt_idx: observed %0d expected %0d", gnt_idx, ei);
        end
        vectors++;
        assert (gnt_valid === ev) else begin
            miscompares++;
            $error("FAIL gnt_valid: observed %b expected %b", gnt_valid, ev);
        end
    endtask

    // Apply one cycle of stimulus, advance the model on the same edge, check 1 time unit later.
    task automatic step(input logic [7:0] r, input logic rs);
        req = r;
        rst = rs;
        @(posedge clk);
        model_update(r, rs);
        #1;
        check_outputs();
    endtask

    // Directed expectation written straight from the scenario; -1 means no grant.
    task automatic expect_idx(input string tag, input int idx);
        logic [7:0] eg;
        eg = (idx < 0) ? 8'h00 : (8'h01 << idx);
        vectors++;
        assert (gnt === eg) else begin
            miscompares++;
            $error("FAIL %s: observed gnt %h expected %h", tag, gnt, eg);
        end
    endtask

    initial begin
        logic [7:0] r;
        req = 8'h00;
        rst = 1'b1;

        // Reset with every requester active.
        step(8'hFF, 1'b1);
        step(8'hFF, 1'b1);
        expect_idx("reset_hold", -1);

        // Rotation: owner drops its request for one cycle after each grant.
        step(8'hFF, 1'b0);
        expect_idx("rot_0", 0);
        for (int k = 1; k <= 8; k++) begin
            step(8'hFF & ~(8'h01 << ((k - 1) % 8)), 1'b0);
            expect_idx($sformatf("rot_%0d", k), k % 8);
        end

        // Wrap: grant 6, then 6 releases with 0 waiting and 7 absent.
        step(8'h40, 1'b0);
        expect_idx("wrap_to6", 6);
        step(8'b0100_0001, 1'b0);
        expect_idx("wrap_hold6", 6);
        step(8'b0000_0001, 1'b0);
        expect_idx("wrap_to0", 0);

        // Preemption, late competitor: 2 saturates alone, then 5 appears.
        step(8'h00, 1'b1);
        step(8'h04, 1'b0);
        for (int i = 0; i < 9; i++) step(8'h04, 1'b0);
        expect_idx("sat_hold2", 2);
        step(8'h24, 1'b0);
        expect_idx("preempt_late", 5);

        // Preemption, early competitor: 2 keeps the grant for HM cycles.
        step(8'h00, 1'b1);
        step(8'h04, 1'b0);
        for (int i = 0; i < HM - 1; i++) begin
            step(8'h24, 1'b0);
            expect_idx("preempt_wait", 2);
        end
        step(8'h24, 1'b0);
        expect_idx("preempt_early", 5);

        // Release to idle after a three-cycle pulse.
        step(8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(8'h08, 1'b0);
            expect_idx("pulse_own3", 3);
        end
        step(8'h00, 1'b0);
        expect_idx("pulse_idle", -1);

        // Reset while 5 owns the grant.
        step(8'h20, 1'b0);
        expect_idx("mid_own5", 5);
        step(8'hFF, 1'b1);
        expect_idx("mid_rst", -1);
        step(8'hFF, 1'b0);
        expect_idx("mid_after", 0);

        // Random traffic, sparse and dense, with occasional reset.
        for (int i = 0; i < 400; i++) begin
            r = 8'($urandom);
            if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
            step(r, ($urandom_range(0, 49) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
